// File: rtl/seg7_decoder.sv
// seg7_decoder: debounces an active-low 7-segment bus and queues decoded hex digits in a FIFO.
// Optional SEG7_DEC_ERRCNT_EN enables a saturating err_cnt counter. Rev 1.0
`default_nettype none

module seg7_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  input  logic       clr,
  output logic [3:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err,
  output logic       ovf,
  output logic [7:0] err_cnt
);

  localparam int         AW     = $clog2(FIFO_DEPTH);
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
  localparam logic [6:0] BLANK  = 7'h7F;

  localparam logic [0:0] SETTLE = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]  state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [6:0]  sample, prev, last;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [3:0]  mem [FIFO_DEPTH];

  logic       same, accept, is_new, push, pop, full, push_ok, err_set;
  logic [4:0] dec;

  // Returns {valid, digit}; valid=0 for blank and for unrecognised codes.
  function automatic logic [4:0] decode(input logic [6:0] code);
    logic [4:0] r;
    r = 5'h00;
    case (code)
      7'h40: r = 5'h10;
      7'h79: r = 5'h11;
      7'h24: r = 5'h12;
      7'h30: r = 5'h13;
      7'h19: r = 5'h14;
      7'h12: r = 5'h15;
      7'h02: r = 5'h16;
      7'h78: r = 5'h17;
      7'h00: r = 5'h18;
      7'h10: r = 5'h19;
      7'h08: r = 5'h1A;
      7'h03: r = 5'h1B;
      7'h46: r = 5'h1C;
      7'h21: r = 5'h1D;
      7'h06: r = 5'h1E;
      7'h0E: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    same    = (sample == prev);
    cnt_nxt = 8'd1;
    if (same) cnt_nxt = (cnt >= STABLE) ? STABLE : cnt + 8'd1;
    accept    = (state == SETTLE) && (cnt_nxt == STABLE);
    state_nxt = state;
    case (state)
      SETTLE:  if (accept) state_nxt = LOCKED;
      LOCKED:  if (!same) state_nxt = SETTLE;
      default: state_nxt = SETTLE;
    endcase
    dec     = decode(sample);
    is_new  = accept && (sample != last);
    push    = is_new && dec[4];
    err_set = is_new && !dec[4] && (sample != BLANK);
  end

  assign out_valid = (wr_ptr != rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO can still take the push.
  assign push_ok   = push && (!full || pop);
  assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : 4'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= SETTLE;
      cnt    <= 8'd0;
      sample <= BLANK;
      prev   <= BLANK;
      last   <= BLANK;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      sample <= seg;
      prev   <= sample;
      err    <= err_set;
      if (accept) last <= sample;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !push_ok) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr && push_ok) mem[wr_ptr[AW-1:0]] <= dec[3:0];
  end

`ifdef SEG7_DEC_ERRCNT_EN
  logic [7:0] err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count <= 8'd0;
    else if (clr) err_count <= 8'd0;
    else if (err_set && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
  end

  assign err_cnt = err_count;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seg7_decoder.sv
// tb_seg7_decoder: directed self-checking bench for seg7_decoder (STABLE_CYCLES=4, FIFO_DEPTH=4).
`default_nettype none

module tb_seg7_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg;
  logic       clr;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       err;
  logic       ovf;
  logic [7:0] err_cnt;

  int checks   = 0;
  int failures = 0;

`ifdef SEG7_DEC_ERRCNT_EN
  localparam logic [7:0] ERRCNT_AFTER_ONE = 8'd1;
`else
  localparam logic [7:0] ERRCNT_AFTER_ONE = 8'd0;
`endif

  seg7_decoder #(.STABLE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .clr(clr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err(err), .ovf(ovf), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a code from the next edge, let it be accepted, then return to a settled blank.
  task automatic push_code(input logic [6:0] code);
    seg = code;
    tick(5);
    seg = 7'h7F;
    tick(5);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; seg = 7'h7F; clr = 1'b0; out_ready = 1'b0;
    #3;
    checks++;
    if ({out_valid, out_data, err, ovf, err_cnt} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {out_valid, out_data, err, ovf, err_cnt});
    end
    tick(2);
    rst_n = 1'b1;
    tick(6);
    checks++;
    if ({out_valid, err, ovf} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=000", {out_valid, err, ovf});
    end
  endtask

  task automatic test_single_digit();
    seg = 7'h79;
    for (int e = 1; e <= 4; e++) begin
      tick(1);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL digit1_early edge=%0d out_valid got=%b exp=0", e, out_valid);
      end
    end
    tick(1);
    checks++;
    if ({out_valid, out_data, err} !== {1'b1, 4'd1, 1'b0}) begin
      failures++;
      $display("FAIL digit1_edge5 got v=%b d=%h e=%b exp v=1 d=1 e=0", out_valid, out_data, err);
    end
    tick(5);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL digit1_single_push out_valid got=%b exp=0", out_valid);
    end
    seg = 7'h7F;
    tick(6);
  endtask

  task automatic test_glitch();
    seg = 7'h24;
    tick(2);
    seg = 7'h7F;
    tick(1);
    seg = 7'h24;
    for (int e = 4; e <= 7; e++) begin
      tick(1);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL glitch_early edge=%0d out_valid got=%b exp=0", e, out_valid);
      end
    end
    tick(1);
    checks++;
    if ({out_valid, out_data} !== {1'b1, 4'd2}) begin
      failures++;
      $display("FAIL glitch_push got v=%b d=%h exp v=1 d=2", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL glitch_single_push out_valid got=%b exp=0", out_valid);
    end
    seg = 7'h7F;
    tick(6);
  endtask

  task automatic test_invalid();
    seg = 7'h55;
    tick(4);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL invalid_early err got=%b exp=0", err);
    end
    tick(1);
    checks++;
    if ({err, err_cnt, out_valid} !== {1'b1, ERRCNT_AFTER_ONE, 1'b0}) begin
      failures++;
      $display("FAIL invalid_pulse got err=%b cnt=%0d v=%b exp err=1 cnt=%0d v=0",
               err, err_cnt, out_valid, ERRCNT_AFTER_ONE);
    end
    tick(1);
    checks++;
    if ({err, out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL invalid_one_cycle got err=%b v=%b exp 0 0", err, out_valid);
    end
    seg = 7'h7F;
    tick(6);
  endtask

  task automatic test_overflow();
    logic [6:0] codes [5];
    codes[0] = 7'h79; codes[1] = 7'h24; codes[2] = 7'h30; codes[3] = 7'h19; codes[4] = 7'h12;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_code(codes[i]);
    checks++;
    if ({out_valid, ovf} !== 2'b11) begin
      failures++;
      $display("FAIL ovf_set got v=%b ovf=%b exp 1 1", out_valid, ovf);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if ({out_valid, out_data} !== {1'b1, 4'(i)}) begin
        failures++;
        $display("FAIL ovf_pop%0d got v=%b d=%h exp v=1 d=%0d", i, out_valid, out_data, i);
      end
      tick(1);
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_drained out_valid got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_full_with_pop();
    logic [3:0] exp_seq [4];
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL clr_ovf got=%b exp=0", ovf);
    end
    push_code(7'h02); push_code(7'h78); push_code(7'h00); push_code(7'h10);
    seg = 7'h08;
    tick(4);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    checks++;
    if ({ovf, out_valid, out_data} !== {1'b0, 1'b1, 4'h7}) begin
      failures++;
      $display("FAIL full_pop_push got ovf=%b v=%b d=%h exp ovf=0 v=1 d=7", ovf, out_valid, out_data);
    end
    seg = 7'h7F;
    tick(6);
    exp_seq[0] = 4'h7; exp_seq[1] = 4'h8; exp_seq[2] = 4'h9; exp_seq[3] = 4'hA;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, out_data} !== {1'b1, exp_seq[i]}) begin
        failures++;
        $display("FAIL full_order%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_seq[i]);
      end
      tick(1);
    end
    out_ready = 1'b0;
    checks++;
    if ({out_valid, ovf} !== 2'b00) begin
      failures++;
      $display("FAIL full_drained got v=%b ovf=%b exp 0 0", out_valid, ovf);
    end
  endtask

  task automatic test_clr_with_push();
    push_code(7'h03); push_code(7'h46); push_code(7'h21); push_code(7'h06);
    seg = 7'h0E;
    tick(4);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    checks++;
    if ({out_valid, ovf, err_cnt} !== 10'd0) begin
      failures++;
      $display("FAIL clr_push got v=%b ovf=%b cnt=%0d exp 0 0 0", out_valid, ovf, err_cnt);
    end
    tick(3);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL clr_stays_empty out_valid got=%b exp=0", out_valid);
    end
    seg = 7'h7F;
    tick(6);
  endtask

  task automatic test_reset_midstream();
    push_code(7'h30);
    seg = 7'h10;
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, err, ovf, err_cnt} !== 15'd0) begin
      failures++;
      $display("FAIL midreset_outputs got=%h exp=0", {out_valid, out_data, err, ovf, err_cnt});
    end
    tick(2);
    checks++;
    if ({out_valid, out_data, err, ovf, err_cnt} !== 15'd0) begin
      failures++;
      $display("FAIL midreset_held got=%h exp=0", {out_valid, out_data, err, ovf, err_cnt});
    end
    rst_n = 1'b1;
    tick(4);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL release_early out_valid got=%b exp=0", out_valid);
    end
    tick(1);
    checks++;
    if ({out_valid, out_data} !== {1'b1, 4'h9}) begin
      failures++;
      $display("FAIL release_push got v=%b d=%h exp v=1 d=9", out_valid, out_data);
    end
    tick(5);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL release_single_push out_valid got=%b exp=0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_glitch();
    test_invalid();
    test_overflow();
    test_full_with_pop();
    test_clr_with_push();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg7_decoder.md
SEG7_DECODER -- requirements
Module: seg7_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical samples required before a pattern is accepted; legal range 2..255.
REQ-002 Parameter FIFO_DEPTH, default 4: decoded-digit FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 seg  input  7  segment bus, active-low (0 = lit), seg[0]=a through seg[6]=g; asynchronous to the producer.
REQ-006 clr  input  1  synchronous clear of FIFO, ovf and err_cnt.
REQ-007 out_data  output  4  hex digit at the FIFO head.
REQ-008 out_valid  output  1  FIFO non-empty.
REQ-009 out_ready  input  1  consumer accepts the head when out_valid && out_ready at a rising edge.
REQ-010 err  output  1  one-cycle pulse: an unrecognised pattern was accepted.
REQ-011 ovf  output  1  sticky: a digit was dropped because the FIFO was full.
REQ-012 err_cnt  output  8  saturating error count (see Configuration).

Function
REQ-013 Decode table (seg hex -> digit): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F; 7F = blank; every other code is invalid.
REQ-014 seg is registered once per cycle (sample register); all filtering operates on the sampled value.
REQ-015 Filter FSM has two states: SETTLE and LOCKED; the 8-bit run counter saturates at STABLE_CYCLES.
REQ-016 SETTLE: sample equal to previous sample -> counter +1; sample differs -> counter = 1.
REQ-017 SETTLE: when the counter reaches STABLE_CYCLES, the sample is accepted and the FSM moves to LOCKED.
REQ-018 LOCKED: any sample change -> SETTLE with counter = 1; no event is generated on leaving LOCKED.
REQ-019 Acceptance of a pattern identical to the last accepted pattern generates no event; this covers a glitch that returns to the same code.
REQ-020 Acceptance of a new valid digit pushes the digit into the FIFO.
REQ-021 Acceptance of a new invalid code pulses err for exactly one cycle and pushes nothing.
REQ-022 Acceptance of blank (7F) updates the last-accepted pattern only.
REQ-023 Latency: a pattern present on seg from clock edge 1 is pushed at edge STABLE_CYCLES+1; with the FIFO empty, out_valid is high after that edge; err pulses in the same cycle.
REQ-024 FIFO pop occurs when out_valid && out_ready; out_data shows the head combinationally from the FIFO storage.
REQ-025 Push to a full FIFO with a simultaneous pop: the push is accepted.
REQ-026 Push to a full FIFO without a pop: the digit is dropped and ovf is set.
REQ-027 Pop with an empty FIFO has no effect.
REQ-028 Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
REQ-029 clr has priority over push/pop in the same cycle: FIFO empties, ovf=0, err_cnt=0.
REQ-030 clr does not disturb the filter FSM or the last-accepted pattern.

Reset
REQ-031 On rst_n low, immediately and regardless of clk: FSM = SETTLE, counter = 0, sample register = 7F, last accepted = 7F.
REQ-032 On rst_n low, the FIFO is emptied and pointers = 0.
REQ-033 On rst_n low, outputs are out_valid=0, out_data=0, err=0, ovf=0, err_cnt=0.
REQ-034 Reset mid-acceptance discards the partial run; a digit held across reset release is accepted once, STABLE_CYCLES+1 edges after release.

Configuration
REQ-035 Macro SEG7_DEC_ERRCNT_EN defined: err_cnt increments on every err pulse and saturates at 255.
REQ-036 Macro SEG7_DEC_ERRCNT_EN undefined: err_cnt is tied to 0 and no counter logic exists; the port is always present.

Verification
REQ-037 Reset, then seg=79 held for 10 cycles -> exactly one push; out_data=1 and out_valid=1 after edge 5; err=0.
REQ-038 seg=24 for 2 cycles, 7F for 1 cycle, then 24 held -> nothing pushed before the hold completes 4 samples; exactly one digit 2 pushed.
REQ-039 seg=55 held -> err high for exactly one cycle; err_cnt=1 with SEG7_DEC_ERRCNT_EN, 0 without; FIFO stays empty.
REQ-040 out_ready=0; digits 1,2,3,4,5 each separated by blank -> FIFO holds 1,2,3,4 and ovf=1; then out_ready=1 -> pops 1,2,3,4, and out_valid=0 afterwards.
REQ-041 FIFO full with out_ready=1 in the push cycle -> no ovf; pop order preserved.
REQ-042 clr asserted in the same cycle as a push -> FIFO empty, ovf=0, err_cnt=0 on the next cycle; rst_n pulsed mid-stream -> all outputs 0 while low.
